spio_spinnaker_link_pkt_serializer: RTL and testbench
=====================================================

// Module: spio_spinnaker_link_pkt_serializer
// PURPOSE
//  Converts whole SpiNNaker packets (40-bit, or 72-bit with payload) into a stream of
//  2-of-7 NRZ flits, nibble by nibble, LSB first, then one EOP flit. Sits directly
//  upstream of the link sync-to-async FIFO. Its flt_* outputs give the new absolute
//  wire level, which the FIFO drives straight onto SL_DATA_2OF7_OUT.
// PARAMETERS
//  (none tunable; fixed by link protocol)
//  localparam EOP_SYM = 7'b1100000 : end-of-packet symbol
// PORTS
//  CLK_IN         in   1   clock
//  RESET_IN       in   1   reset, asynchronous, active-high
//  PKT_DATA_IN    in   72  packet; [39:0] used if PKT_DATA_IN[1]==0 (no payload)
//  PKT_VLD_IN     in   1   packet valid
//  PKT_RDY_OUT    out  1   packet ready; transfer when VLD&&RDY on CLK_IN edge
//  flt_data_2of7  out  7   next wire level = previous level XOR symbol
//  flt_vld        out  1   flit valid
//  flt_rdy        in   1   FIFO ready; flit transfer when flt_vld&&flt_rdy
// BEHAVIOUR
//  - Reset: state IDLE, PKT_RDY_OUT=1, flt_vld=0, flt_data_2of7=7'd0 (matches link reset level).
//  - States: IDLE -> SEND -> EOP -> IDLE. PKT_RDY_OUT = (state==IDLE), registered.
//  - IDLE: on packet transfer latch packet, nflits = 10 (PKT_DATA_IN[1]=0) or 18 (=1);
//    flt_data <= flt_data ^ CODE(nibble0); flt_vld<=1; go SEND. First flit 1 cycle later.
//  - SEND: on flit transfer, idx++; if idx was nflits-1: flt_data ^= EOP_SYM, go EOP;
//    else flt_data ^= CODE(nibble idx+1). No transfer -> flt_data/flt_vld held stable.
//  - EOP: on flit transfer flt_vld<=0, go IDLE. Inter-packet gap >= 1 idle cycle.
//  - Throughput: 1 flit/cycle while flt_rdy high; flt_rdy may drop any cycle (FIFO full).
//  - CODE nibble 0..F: 11 12 14 18 21 22 24 28 41 42 44 48 03 06 0C 09 (hex, 7-bit).
//  - flt_data register is the link level; it is never cleared between packets.
//  - Nibble index counter 5 bits; values >= nflits unreachable.
//  - PKT_DATA_IN ignored outside IDLE; PKT_VLD_IN with PKT_RDY_OUT=0 has no effect.
//  - Reset mid-packet: packet discarded, all outputs to reset values immediately.
// CONFIGURATION
//  PKT_PARITY_GEN_EN defined: on latch, bit0 overwritten so whole packet (40 or 72 bits)
//    has odd parity; nibble0 encoded from corrected value.
//  Not defined: packet transmitted bit-exact; parity is the producer's responsibility.
// TESTING
//  1 Reset, 40-bit all-zero pkt, flt_rdy=1 -> flits 11,00,11,00,..(10, last 00), then 60;
//    flt_vld low after EOP; PKT_RDY_OUT high again.
//  2 72-bit pkt hdr byte 0x02, rest 0 -> first flit 14, then 17 flits alternating with 11
//    code, EOP 19th flit; flit count 19 exactly.
//  3 flt_rdy toggled 1,0,0,1 per cycle during pkt 1 -> same flit sequence, data stable
//    while flt_rdy=0, no flit lost/duplicated.
//  4 Back-to-back: 2 pkts, PKT_VLD_IN held high -> second accepted the cycle after EOP
//    transfer; level continues from 60 (first flit 60^CODE).
//  5 RESET_IN pulsed after 4th flit -> flt_vld=0, flt_data=00, PKT_RDY_OUT=1; next pkt
//    sent from level 00 correctly.
//  6 PKT_PARITY_GEN_EN: 40-bit all-zero pkt -> first flit 12; undefined: 11.

Source files
------------

// File: rtl/spio_spinnaker_link_pkt_serializer.sv
// SpiNNaker link packet serializer: 40/72-bit packets to 2-of-7 NRZ flits plus EOP.
// Optional build macro PKT_PARITY_GEN_EN forces odd packet parity through bit 0 on latch.
module spio_spinnaker_link_pkt_serializer (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    input  logic [71:0] PKT_DATA_IN,
    input  logic        PKT_VLD_IN,
    output logic        PKT_RDY_OUT,
    output logic [6:0]  flt_data_2of7,
    output logic        flt_vld,
    input  logic        flt_rdy
);

    // state | meaning
    // IDLE  | waiting for a packet, PKT_RDY_OUT high
    // SEND  | presenting data flits, one nibble each, LSB first
    // EOP   | presenting the end-of-packet flit
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_EOP  = 2'd2;

    localparam logic [6:0] EOP_SYM = 7'b1100000;

    function automatic logic [6:0] code_2of7(input logic [3:0] nib);
        logic [6:0] c;
        case (nib)
            4'h0: c = 7'h11;
            4'h1: c = 7'h12;
            4'h2: c = 7'h14;
            4'h3: c = 7'h18;
            4'h4: c = 7'h21;
            4'h5: c = 7'h22;
            4'h6: c = 7'h24;
            4'h7: c = 7'h28;
            4'h8: c = 7'h41;
            4'h9: c = 7'h42;
            4'hA: c = 7'h44;
            4'hB: c = 7'h48;
            4'hC: c = 7'h03;
            4'hD: c = 7'h06;
            4'hE: c = 7'h0C;
            default: c = 7'h09;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [71:0] p, input logic [4:0] idx);
        logic [71:0] sh;
        sh = p >> {idx, 2'b00};
        return sh[3:0];
    endfunction

    logic [1:0]  state;
    logic [71:0] pkt;
    logic [71:0] pkt_in;
    logic [4:0]  idx;
    logic [4:0]  last_idx;
    logic        pkt_xfer;
    logic        flt_xfer;

    assign pkt_xfer = PKT_VLD_IN && PKT_RDY_OUT;
    assign flt_xfer = flt_vld && flt_rdy;
    assign last_idx = pkt[1] ? 5'd17 : 5'd9;

    always_comb begin
        pkt_in = PKT_DATA_IN;
`ifdef PKT_PARITY_GEN_EN
        // bit 0 chosen so the transmitted bits (40 or 72) have odd parity
        if (PKT_DATA_IN[1])
            pkt_in[0] = ~^PKT_DATA_IN[71:1];
        else
            pkt_in[0] = ~^PKT_DATA_IN[39:1];
`endif
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state         <= ST_IDLE;
            pkt           <= '0;
            idx           <= '0;
            flt_data_2of7 <= '0;
            flt_vld       <= 1'b0;
            PKT_RDY_OUT   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pkt_xfer) begin
                        pkt           <= pkt_in;
                        idx           <= '0;
                        flt_data_2of7 <= flt_data_2of7 ^ code_2of7(pkt_in[3:0]);
                        flt_vld       <= 1'b1;
                        PKT_RDY_OUT   <= 1'b0;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (flt_xfer) begin
                        idx <= idx + 5'd1;
                        if (idx == last_idx) begin
                            flt_data_2of7 <= flt_data_2of7 ^ EOP_SYM;
                            state         <= ST_EOP;
                        end else begin
                            flt_data_2of7 <= flt_data_2of7 ^ code_2of7(nibble_at(pkt, idx + 5'd1));
                        end
                    end
                end
                ST_EOP: begin
                    if (flt_xfer) begin
                        flt_vld     <= 1'b0;
                        PKT_RDY_OUT <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    flt_vld     <= 1'b0;
                    PKT_RDY_OUT <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spio_spinnaker_link_pkt_serializer.sv
// Bench for spio_spinnaker_link_pkt_serializer: queue-of-wire-levels model plus directed literals.
module tb_spio_spinnaker_link_pkt_serializer;

    logic        CLK_IN = 1'b0;
    logic        RESET_IN = 1'b0;
    logic [71:0] PKT_DATA_IN = '0;
    logic        PKT_VLD_IN = 1'b0;
    logic        PKT_RDY_OUT;
    logic [6:0]  flt_data_2of7;
    logic        flt_vld;
    logic        flt_rdy = 1'b1;

    int checks = 0;
    int errors = 0;

    spio_spinnaker_link_pkt_serializer dut (
        .CLK_IN        (CLK_IN),
        .RESET_IN      (RESET_IN),
        .PKT_DATA_IN   (PKT_DATA_IN),
        .PKT_VLD_IN    (PKT_VLD_IN),
        .PKT_RDY_OUT   (PKT_RDY_OUT),
        .flt_data_2of7 (flt_data_2of7),
        .flt_vld       (flt_vld),
        .flt_rdy       (flt_rdy)
    );

    always #5 CLK_IN = ~CLK_IN;

    logic [6:0] CODE [16] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                              7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09};

    // Model: wire levels still to be presented, and the last level already on the wire.
    logic [6:0] exp_q [$];
    logic [6:0] level = '0;
    logic [6:0] obs [$];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_packet(input logic [71:0] p_in);
        logic [71:0] p;
        logic [71:0] t;
        logic [6:0]  lv;
        int n;
        p = p_in;
        n = p[1] ? 18 : 10;
`ifdef PKT_PARITY_GEN_EN
        begin
            int ones;
            ones = 0;
            for (int b = 1; b < n * 4; b++) ones += int'(p[b]);
            p[0] = (ones % 2 == 0);
        end
`endif
        lv = level;
        for (int i = 0; i < n; i++) begin
            t = p >> (4 * i);
            lv = lv ^ CODE[t[3:0]];
            exp_q.push_back(lv);
        end
        exp_q.push_back(lv ^ 7'h60);
    endtask

    always @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            exp_q.delete();
            level = '0;
        end else if (exp_q.size() != 0) begin
            if (flt_rdy) level = exp_q.pop_front();
        end else if (PKT_VLD_IN) begin
            push_packet(PKT_DATA_IN);
        end
    end

    always @(negedge CLK_IN) begin
        logic       ev;
        logic [6:0] ed;
        ev = (exp_q.size() != 0);
        ed = ev ? exp_q[0] : level;
        chk("flt_vld", 72'(flt_vld), 72'(ev));
        chk("flt_data", 72'(flt_data_2of7), 72'(ed));
        chk("pkt_rdy", 72'(PKT_RDY_OUT), 72'(!ev));
        if (!RESET_IN && flt_vld && flt_rdy) obs.push_back(flt_data_2of7);
    end

    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic do_reset();
        RESET_IN = 1'b1;
        #1;
        chk("rst_vld", 72'(flt_vld), 72'd0);
        chk("rst_data", 72'(flt_data_2of7), 72'd0);
        chk("rst_rdy", 72'(PKT_RDY_OUT), 72'd1);
        step();
        step();
        RESET_IN = 1'b0;
    endtask

    task automatic send_one(input logic [71:0] d);
        PKT_DATA_IN = d;
        PKT_VLD_IN  = 1'b1;
        step();
        PKT_VLD_IN  = 1'b0;
    endtask

    task automatic wait_flits(input int n, input int budget, input bit toggle);
        logic [3:0] pat;
        int cyc;
        pat = 4'b1001;
        cyc = 0;
        while (obs.size() < n && cyc < budget) begin
            if (toggle) flt_rdy = pat[3 - (cyc % 4)];
            step();
            cyc++;
        end
        flt_rdy = 1'b1;
        chk("flit_count_timeout", 72'(obs.size() >= n), 72'd1);
    endtask

    logic [6:0] exp1 [11];

    task automatic chk_zero_pkt(input string nm, input int base);
        for (int i = 0; i < 11; i++)
            if (base + i < obs.size()) chk(nm, 72'(obs[base + i]), 72'(exp1[i]));
    endtask

    initial begin
`ifdef PKT_PARITY_GEN_EN
        exp1 = '{7'h12, 7'h03, 7'h12, 7'h03, 7'h12, 7'h03, 7'h12, 7'h03, 7'h12, 7'h03, 7'h63};
`else
        exp1 = '{7'h11, 7'h00, 7'h11, 7'h00, 7'h11, 7'h00, 7'h11, 7'h00, 7'h11, 7'h00, 7'h60};
`endif
        do_reset();

        // 40-bit all-zero packet at full rate
        obs.delete();
        send_one('0);
        wait_flits(11, 40, 1'b0);
        repeat (3) step();
        chk("t1_count", 72'(obs.size()), 72'd11);
        chk_zero_pkt("t1_seq", 0);

        // 72-bit packet, header byte 0x02
        do_reset();
        obs.delete();
        send_one(72'h02);
        wait_flits(19, 60, 1'b0);
        repeat (4) step();
        chk("t2_count", 72'(obs.size()), 72'd19);
        if (obs.size() == 19) begin
            chk("t2_first", 72'(obs[0]), 72'h14);
            chk("t2_second", 72'(obs[1]), 72'h05);
            chk("t2_eop", 72'(obs[18]), 72'h65);
        end

        // back-pressure pattern 1,0,0,1
        do_reset();
        obs.delete();
        send_one('0);
        wait_flits(11, 80, 1'b1);
        repeat (3) step();
        chk("t3_count", 72'(obs.size()), 72'd11);
        chk_zero_pkt("t3_seq", 0);

        // back-to-back with PKT_VLD_IN held
        do_reset();
        obs.delete();
        PKT_DATA_IN = '0;
        PKT_VLD_IN  = 1'b1;
        wait_flits(22, 80, 1'b0);
        PKT_VLD_IN  = 1'b0;
        repeat (3) step();
        chk("t4_count", 72'(obs.size()), 72'd22);
        if (obs.size() == 22) begin
            chk("t4_second_first", 72'(obs[11]), 72'h71);
            chk("t4_second_eop", 72'(obs[21]), 72'h00);
        end

        // reset after the 4th flit, then a clean packet from level 00
        do_reset();
        obs.delete();
        send_one('0);
        wait_flits(4, 20, 1'b0);
        do_reset();
        obs.delete();
        send_one('0);
        wait_flits(11, 40, 1'b0);
        repeat (3) step();
        chk("t5_count", 72'(obs.size()), 72'd11);
        chk_zero_pkt("t5_seq", 0);

        // randomized traffic with random back-pressure and rare resets
        for (int c = 0; c < 4000; c++) begin
            PKT_DATA_IN = {$urandom, $urandom, $urandom};
            PKT_VLD_IN  = ($urandom_range(0, 1) == 1);
            flt_rdy     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step();
        end
        PKT_VLD_IN = 1'b0;
        flt_rdy    = 1'b1;
        repeat (40) step();
        chk("drained_vld", 72'(flt_vld), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
